// File: rtl/axil_imem_loader.sv
// AXI4-Lite slave holding the CPU instruction store, a read-only view of the CPU
// register file, a run/clear control register and a saturating run-cycle counter.
module axil_imem_loader #(
  parameter int ADDR_W = 9,
  parameter int NWORDS = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_W-1:0]     s_awaddr,
  input  logic                  s_awvalid,
  output logic                  s_awready,
  input  logic [31:0]           s_wdata,
  input  logic [3:0]            s_wstrb,
  input  logic                  s_wvalid,
  output logic                  s_wready,
  output logic [1:0]            s_bresp,
  output logic                  s_bvalid,
  input  logic                  s_bready,
  input  logic [ADDR_W-1:0]     s_araddr,
  input  logic                  s_arvalid,
  output logic                  s_arready,
  output logic [31:0]           s_rdata,
  output logic [1:0]            s_rresp,
  output logic                  s_rvalid,
  input  logic                  s_rready,
  output logic [32*NWORDS-1:0]  idata_flat,
  input  logic [32*NWORDS-1:0]  regs_flat,
  output logic                  cpu_reset,
  output logic                  cpu_running
);

  localparam int IDX_W  = ADDR_W - 2;
  localparam int SLOT_W = $clog2(NWORDS);
  localparam logic [IDX_W-1:0] CTRL_IDX = IDX_W'(2 * NWORDS);
  localparam logic [IDX_W-1:0] CYC_IDX  = IDX_W'(2 * NWORDS + 1);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    REG_INST,
    REG_SNAP,
    REG_CTRL,
    REG_CYC,
    REG_NONE
  } region_e;

  function automatic region_e decode_region(input logic [IDX_W-1:0] idx);
    if (idx < IDX_W'(NWORDS))          return REG_INST;
    else if (idx < IDX_W'(2 * NWORDS)) return REG_SNAP;
    else if (idx == CTRL_IDX)          return REG_CTRL;
    else if (idx == CYC_IDX)           return REG_CYC;
    else                               return REG_NONE;
  endfunction

  // State
  logic                r_live;
  logic                r_aw_held;
  logic [IDX_W-1:0]    r_aw_idx;
  logic                r_w_held;
  logic [31:0]         r_wdata;
  logic [3:0]          r_wstrb;
  logic                r_bvalid;
  logic [1:0]          r_bresp;
  logic                r_rvalid;
  logic [31:0]         r_rdata;
  logic [1:0]          r_rresp;
  logic [31:0]         r_mem [NWORDS];
  logic                r_run;
  logic                r_cpu_reset;
  logic [31:0]         r_cycles;

  // Combinational decode
  logic                w_commit;
  logic [SLOT_W-1:0]   w_wr_slot;
  logic                w_inst_we;
  logic                w_ctrl_we;
  logic                w_clear;
  logic [1:0]          w_wr_resp;
  logic                w_run_rise;
  logic [IDX_W-1:0]    w_rd_idx;
  logic [SLOT_W-1:0]   w_rd_slot;
  logic [31:0]         w_rd_data;
  logic [1:0]          w_rd_resp;
  logic [31:0]         w_regs [NWORDS];
  logic                w_unused_addr;

  // Byte-offset address bits carry no meaning for a word-wide register map.
  assign w_unused_addr = ^{s_awaddr[1:0], s_araddr[1:0]};

  assign s_awready   = r_live & ~r_aw_held & ~r_bvalid;
  assign s_wready    = r_live & ~r_w_held & ~r_bvalid;
  assign s_bvalid    = r_bvalid;
  assign s_bresp     = r_bresp;
  assign s_arready   = r_live & ~r_rvalid;
  assign s_rvalid    = r_rvalid;
  assign s_rdata     = r_rdata;
  assign s_rresp     = r_rresp;
  assign cpu_reset   = r_cpu_reset;
  assign cpu_running = r_run;

  always_comb begin
    for (int k = 0; k < NWORDS; k++) begin
      idata_flat[32*k +: 32] = r_mem[k];
      w_regs[k]              = regs_flat[32*k +: 32];
    end
  end

  // NOTE: every output of an always_comb gets a default before any branch so no
  // path leaves a value unassigned, which would otherwise infer a latch.
  always_comb begin
    w_commit  = r_aw_held & r_w_held;
    w_wr_slot = r_aw_idx[SLOT_W-1:0];
    w_inst_we = 1'b0;
    w_ctrl_we = 1'b0;
    w_clear   = 1'b0;
    w_wr_resp = RESP_OKAY;
    if (w_commit) begin
      case (decode_region(r_aw_idx))
        REG_INST: begin
          if (r_run) w_wr_resp = RESP_SLVERR;
          else       w_inst_we = 1'b1;
        end
        REG_CTRL: begin
          // A clear while running is refused outright, leaving run untouched too.
          if (r_wstrb[0]) begin
            if (r_wdata[1] && r_run) begin
              w_wr_resp = RESP_SLVERR;
            end else begin
              w_ctrl_we = 1'b1;
              w_clear   = r_wdata[1];
            end
          end
        end
        default: w_wr_resp = RESP_SLVERR;
      endcase
    end
    w_run_rise = w_ctrl_we & ~r_run & r_wdata[0];
  end

  always_comb begin
    w_rd_idx  = s_araddr[ADDR_W-1:2];
    w_rd_slot = w_rd_idx[SLOT_W-1:0];
    w_rd_data = '0;
    w_rd_resp = RESP_OKAY;
    case (decode_region(w_rd_idx))
      REG_INST: w_rd_data = r_mem[w_rd_slot];
      REG_SNAP: w_rd_data = w_regs[w_rd_slot];
      REG_CTRL: w_rd_data = {31'd0, r_run};
      REG_CYC:  w_rd_data = r_cycles;
      default:  w_rd_resp = RESP_SLVERR;
    endcase
  end

  // NOTE: the instruction store is reset with everything else so the CPU can never
  // fetch a stale program after a fabric reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < NWORDS; k++) r_mem[k] <= '0;
    end else if (w_clear) begin
      for (int k = 0; k < NWORDS; k++) r_mem[k] <= '0;
    end else if (w_inst_we) begin
      for (int b = 0; b < 4; b++) begin
        if (r_wstrb[b]) r_mem[w_wr_slot][8*b +: 8] <= r_wdata[8*b +: 8];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every block samples
  // pre-edge values; that is what lets a same-cycle read see the pre-write word.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_live    <= 1'b0;
      r_aw_held <= 1'b0;
      r_aw_idx  <= '0;
      r_w_held  <= 1'b0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_bvalid  <= 1'b0;
      r_bresp   <= RESP_OKAY;
    end else begin
      r_live <= 1'b1;
      if (s_awvalid && s_awready) begin
        r_aw_held <= 1'b1;
        r_aw_idx  <= s_awaddr[ADDR_W-1:2];
      end
      if (s_wvalid && s_wready) begin
        r_w_held <= 1'b1;
        r_wdata  <= s_wdata;
        r_wstrb  <= s_wstrb;
      end
      if (w_commit) begin
        r_aw_held <= 1'b0;
        r_w_held  <= 1'b0;
        r_bvalid  <= 1'b1;
        r_bresp   <= w_wr_resp;
      end else if (r_bvalid && s_bready) begin
        r_bvalid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
      r_rresp  <= RESP_OKAY;
    end else if (s_arvalid && s_arready) begin
      r_rvalid <= 1'b1;
      r_rdata  <= w_rd_data;
      r_rresp  <= w_rd_resp;
    end else if (r_rvalid && s_rready) begin
      r_rvalid <= 1'b0;
    end
  end

  // cpu_reset lags the run bit by one cycle so the harness sees a clean edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_run       <= 1'b0;
      r_cpu_reset <= 1'b1;
      r_cycles    <= '0;
    end else begin
      r_cpu_reset <= ~r_run;
      if (w_ctrl_we) r_run <= r_wdata[0];
      if (w_run_rise) begin
        r_cycles <= '0;
      end else if (r_run && !r_cpu_reset && (r_cycles != '1)) begin
        r_cycles <= r_cycles + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_axil_imem_loader.sv
// Self-checking bench for axil_imem_loader: randomized bus traffic against an
// array model of the instruction store, control bits and snapshot view.
module tb_axil_imem_loader;

  localparam int ADDR_W = 9;
  localparam int NWORDS = 32;
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [ADDR_W-1:0]    s_awaddr;
  logic                 s_awvalid;
  logic                 s_awready;
  logic [31:0]          s_wdata;
  logic [3:0]           s_wstrb;
  logic                 s_wvalid;
  logic                 s_wready;
  logic [1:0]           s_bresp;
  logic                 s_bvalid;
  logic                 s_bready;
  logic [ADDR_W-1:0]    s_araddr;
  logic                 s_arvalid;
  logic                 s_arready;
  logic [31:0]          s_rdata;
  logic [1:0]           s_rresp;
  logic                 s_rvalid;
  logic                 s_rready;
  logic [32*NWORDS-1:0] idata_flat;
  logic [32*NWORDS-1:0] regs_flat;
  logic                 cpu_reset;
  logic                 cpu_running;

  logic [31:0] model_mem  [NWORDS];
  logic [31:0] model_regs [NWORDS];
  int          n_checks = 0;
  int          n_fails  = 0;
  int unsigned cyc = 0;
  logic        b_creset_seen;
  int unsigned run_t0;

  axil_imem_loader #(.ADDR_W(ADDR_W), .NWORDS(NWORDS)) dut (
    .clk(clk), .reset(reset),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .idata_flat(idata_flat), .regs_flat(regs_flat),
    .cpu_reset(cpu_reset), .cpu_running(cpu_running)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    for (int k = 0; k < NWORDS; k++) regs_flat[32*k +: 32] = model_regs[k];
  end

  function automatic logic [32*NWORDS-1:0] model_flat();
    logic [32*NWORDS-1:0] v;
    for (int k = 0; k < NWORDS; k++) v[32*k +: 32] = model_mem[k];
    return v;
  endfunction

  function automatic int first_diff(input logic [32*NWORDS-1:0] a, input logic [32*NWORDS-1:0] b);
    for (int k = 0; k < NWORDS; k++) if (a[32*k +: 32] !== b[32*k +: 32]) return k;
    return 0;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] data,
                                        input logic [3:0] strb);
    logic [31:0] v = old;
    for (int b = 0; b < 4; b++) if (strb[b]) v[8*b +: 8] = data[8*b +: 8];
    return v;
  endfunction

  task automatic wait_cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic clear_model();
    for (int k = 0; k < NWORDS; k++) model_mem[k] = '0;
  endtask

  task automatic axi_write(input logic [ADDR_W-1:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, output logic [1:0] resp);
    bit aw_done, w_done, aw_hs, w_hs, got_b;
    s_awaddr = addr; s_awvalid = 1'b1;
    s_wdata = data; s_wstrb = strb; s_wvalid = 1'b1; s_bready = 1'b1;
    aw_done = 0; w_done = 0; got_b = 0; resp = 2'bxx;
    for (int i = 0; i < 40 && !(aw_done && w_done); i++) begin
      aw_hs = s_awvalid && s_awready;
      w_hs  = s_wvalid && s_wready;
      @(posedge clk); #1;
      if (aw_hs) begin s_awvalid = 1'b0; aw_done = 1; end
      if (w_hs)  begin s_wvalid  = 1'b0; w_done  = 1; end
    end
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    if (aw_done && w_done) begin
      for (int i = 0; i < 40 && !got_b; i++) begin
        if (s_bvalid) begin got_b = 1; resp = s_bresp; b_creset_seen = cpu_reset; end
        @(posedge clk); #1;
      end
    end
    s_bready = 1'b0;
    n_checks++;
    if (!got_b) begin
      n_fails++;
      $display("FAIL write_timeout: addr %h got no B response, required one within 40 cycles", addr);
    end
  endtask

  task automatic axi_read(input logic [ADDR_W-1:0] addr, output logic [31:0] data,
                          output logic [1:0] resp);
    bit ar_done, ar_hs, got_r;
    s_araddr = addr; s_arvalid = 1'b1; s_rready = 1'b1;
    ar_done = 0; got_r = 0; data = 'x; resp = 2'bxx;
    for (int i = 0; i < 40 && !ar_done; i++) begin
      ar_hs = s_arready;
      @(posedge clk); #1;
      if (ar_hs) begin s_arvalid = 1'b0; ar_done = 1; end
    end
    s_arvalid = 1'b0;
    if (ar_done) begin
      for (int i = 0; i < 40 && !got_r; i++) begin
        if (s_rvalid) begin got_r = 1; data = s_rdata; resp = s_rresp; end
        @(posedge clk); #1;
      end
    end
    s_rready = 1'b0;
    n_checks++;
    if (!got_r) begin
      n_fails++;
      $display("FAIL read_timeout: addr %h got no R response, required one within 40 cycles", addr);
    end
  endtask

  task automatic test_reset();
    logic [31:0] d; logic [1:0] r;
    reset = 1'b1;
    wait_cycles(3);
    n_checks++;
    if ({s_awready, s_wready, s_arready, s_bvalid, s_rvalid} !== 5'b0) begin
      n_fails++;
      $display("FAIL reset_handshake: got %b required 00000",
               {s_awready, s_wready, s_arready, s_bvalid, s_rvalid});
    end
    n_checks++;
    if (s_bresp !== 2'b0 || s_rresp !== 2'b0 || s_rdata !== 32'h0) begin
      n_fails++;
      $display("FAIL reset_resp: bresp %b rresp %b rdata %h required all zero", s_bresp, s_rresp, s_rdata);
    end
    n_checks++;
    if (idata_flat !== '0) begin
      n_fails++;
      $display("FAIL reset_idata: word %0d got %h required 0", first_diff(idata_flat, '0),
               idata_flat[32*first_diff(idata_flat, '0) +: 32]);
    end
    n_checks++;
    if (cpu_reset !== 1'b1 || cpu_running !== 1'b0) begin
      n_fails++;
      $display("FAIL reset_cpu: cpu_reset %b cpu_running %b required 1 0", cpu_reset, cpu_running);
    end
    reset = 1'b0;
    wait_cycles(1);
    axi_read(9'h104, d, r);
    n_checks++;
    if (d !== 32'h0 || r !== OKAY) begin
      n_fails++;
      $display("FAIL reset_cycles: got %h/%b required 00000000/00", d, r);
    end
    axi_read(9'h100, d, r);
    n_checks++;
    if (d !== 32'h0 || r !== OKAY) begin
      n_fails++;
      $display("FAIL reset_ctrl: got %h/%b required 00000000/00", d, r);
    end
  endtask

  task automatic test_basic_write();
    logic [31:0] d; logic [1:0] r;
    axi_write(9'h000, 32'h00500093, 4'hF, r);
    model_mem[0] = 32'h00500093;
    n_checks++;
    if (r !== OKAY) begin n_fails++; $display("FAIL basic_bresp0: got %b required 00", r); end
    axi_write(9'h004, 32'h00100113, 4'hF, r);
    model_mem[1] = 32'h00100113;
    n_checks++;
    if (r !== OKAY) begin n_fails++; $display("FAIL basic_bresp1: got %b required 00", r); end
    n_checks++;
    if (idata_flat[63:0] !== 64'h00100113_00500093) begin
      n_fails++;
      $display("FAIL basic_idata: got %h required 0010011300500093", idata_flat[63:0]);
    end
    axi_read(9'h000, d, r);
    n_checks++;
    if (d !== 32'h00500093 || r !== OKAY) begin
      n_fails++; $display("FAIL basic_read0: got %h/%b required 00500093/00", d, r);
    end
    axi_read(9'h004, d, r);
    n_checks++;
    if (d !== 32'h00100113 || r !== OKAY) begin
      n_fails++; $display("FAIL basic_read1: got %h/%b required 00100113/00", d, r);
    end
  endtask

  task automatic test_w_before_aw();
    logic early_b;
    early_b = 1'b0;
    n_checks++;
    if (s_wready !== 1'b1) begin n_fails++; $display("FAIL wfirst_wready: got %b required 1", s_wready); end
    s_wdata = 32'hAABBCCDD; s_wstrb = 4'b0101; s_wvalid = 1'b1;
    @(posedge clk); #1;
    s_wvalid = 1'b0;
    repeat (3) begin
      if (s_bvalid) early_b = 1'b1;
      @(posedge clk); #1;
    end
    s_awaddr = 9'h014; s_awvalid = 1'b1;
    if (s_bvalid) early_b = 1'b1;
    @(posedge clk); #1;
    s_awvalid = 1'b0;
    if (s_bvalid) early_b = 1'b1;
    n_checks++;
    if (early_b !== 1'b0) begin n_fails++; $display("FAIL wfirst_early_bvalid: got 1 required 0 before AW"); end
    @(posedge clk); #1;
    model_mem[5] = merge(model_mem[5], 32'hAABBCCDD, 4'b0101);
    n_checks++;
    if (s_bvalid !== 1'b1 || s_bresp !== OKAY) begin
      n_fails++; $display("FAIL wfirst_b: bvalid %b bresp %b required 1 00", s_bvalid, s_bresp);
    end
    n_checks++;
    if (idata_flat[191:160] !== 32'h00BB00DD) begin
      n_fails++; $display("FAIL wfirst_word5: got %h required 00bb00dd", idata_flat[191:160]);
    end
    s_bready = 1'b1;
    @(posedge clk); #1;
    s_bready = 1'b0;
    n_checks++;
    if (s_bvalid !== 1'b0) begin n_fails++; $display("FAIL wfirst_bdrop: got %b required 0", s_bvalid); end
  endtask

  task automatic test_random_inst();
    logic [31:0] d, data; logic [1:0] r; logic [3:0] strb; int w;
    for (int i = 0; i < 24; i++) begin
      w = $urandom_range(0, NWORDS - 1);
      data = $urandom;
      strb = 4'($urandom_range(0, 15));
      axi_write(ADDR_W'(w * 4 + $urandom_range(0, 3)), data, strb, r);
      model_mem[w] = merge(model_mem[w], data, strb);
      n_checks++;
      if (r !== OKAY || idata_flat !== model_flat()) begin
        n_fails++;
        $display("FAIL rand_write: word %0d strb %b bresp %b idata word %0d got %h required %h",
                 w, strb, r, first_diff(idata_flat, model_flat()),
                 idata_flat[32*first_diff(idata_flat, model_flat()) +: 32],
                 model_mem[first_diff(idata_flat, model_flat())]);
      end
    end
    for (int i = 0; i < 8; i++) begin
      w = $urandom_range(0, NWORDS - 1);
      axi_read(ADDR_W'(w * 4), d, r);
      n_checks++;
      if (d !== model_mem[w] || r !== OKAY) begin
        n_fails++; $display("FAIL rand_read: word %0d got %h/%b required %h/00", w, d, r, model_mem[w]);
      end
    end
  endtask

  task automatic test_same_cycle_rw();
    logic [31:0] old_v, new_v, d; logic [1:0] r;
    old_v = model_mem[7];
    new_v = ~old_v;
    s_awaddr = 9'h01C; s_awvalid = 1'b1; s_wdata = new_v; s_wstrb = 4'hF; s_wvalid = 1'b1;
    s_bready = 1'b1;
    @(posedge clk); #1;
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    s_araddr = 9'h01C; s_arvalid = 1'b1; s_rready = 1'b0;
    @(posedge clk); #1;
    s_arvalid = 1'b0;
    model_mem[7] = new_v;
    n_checks++;
    if (s_rvalid !== 1'b1 || s_rdata !== old_v) begin
      n_fails++; $display("FAIL samecyc_old: rvalid %b rdata %h required 1 %h", s_rvalid, s_rdata, old_v);
    end
    n_checks++;
    if (s_bvalid !== 1'b1 || idata_flat[255:224] !== new_v) begin
      n_fails++;
      $display("FAIL samecyc_commit: bvalid %b word7 %h required 1 %h", s_bvalid, idata_flat[255:224], new_v);
    end
    s_rready = 1'b1;
    @(posedge clk); #1;
    s_rready = 1'b0; s_bready = 1'b0;
    axi_read(9'h01C, d, r);
    n_checks++;
    if (d !== new_v || r !== OKAY) begin
      n_fails++; $display("FAIL samecyc_new: got %h/%b required %h/00", d, r, new_v);
    end
  endtask

  task automatic test_snapshot();
    logic [31:0] d; logic [1:0] r; int w;
    for (int k = 0; k < NWORDS; k++) model_regs[k] = $urandom;
    model_regs[3] = 32'h12345678;
    #1;
    axi_read(9'h08C, d, r);
    n_checks++;
    if (d !== 32'h12345678 || r !== OKAY) begin
      n_fails++; $display("FAIL snap_reg3: got %h/%b required 12345678/00", d, r);
    end
    for (int i = 0; i < 4; i++) begin
      w = $urandom_range(0, NWORDS - 1);
      axi_read(ADDR_W'(9'h080 + w * 4), d, r);
      n_checks++;
      if (d !== model_regs[w] || r !== OKAY) begin
        n_fails++; $display("FAIL snap_rand: reg %0d got %h/%b required %h/00", w, d, r, model_regs[w]);
      end
    end
    axi_read(9'h150, d, r);
    n_checks++;
    if (d !== 32'h0 || r !== SLVERR) begin
      n_fails++; $display("FAIL unmapped_read: got %h/%b required 00000000/10", d, r);
    end
    axi_write(9'h084, $urandom, 4'hF, r);
    n_checks++;
    if (r !== SLVERR) begin n_fails++; $display("FAIL snap_write: got %b required 10", r); end
    axi_write(9'h104, $urandom, 4'hF, r);
    n_checks++;
    if (r !== SLVERR) begin n_fails++; $display("FAIL cycles_write: got %b required 10", r); end
    axi_write(9'h150, $urandom, 4'hF, r);
    n_checks++;
    if (r !== SLVERR || idata_flat !== model_flat()) begin
      n_fails++;
      $display("FAIL unmapped_write: bresp %b word %0d got %h required 10 %h", r,
               first_diff(idata_flat, model_flat()),
               idata_flat[32*first_diff(idata_flat, model_flat()) +: 32],
               model_mem[first_diff(idata_flat, model_flat())]);
    end
  endtask

  task automatic test_run();
    logic [31:0] d; logic [1:0] r;
    run_t0 = cyc;
    axi_write(9'h100, 32'h1, 4'b0001, r);
    n_checks++;
    if (r !== OKAY) begin n_fails++; $display("FAIL run_bresp: got %b required 00", r); end
    n_checks++;
    if (b_creset_seen !== 1'b1) begin
      n_fails++; $display("FAIL run_creset_n1: got %b required 1 one cycle after commit", b_creset_seen);
    end
    n_checks++;
    if (cpu_reset !== 1'b0 || cpu_running !== 1'b1) begin
      n_fails++;
      $display("FAIL run_creset_n2: cpu_reset %b running %b required 0 1", cpu_reset, cpu_running);
    end
    wait_cycles(10);
    axi_read(9'h104, d, r);
    n_checks++;
    if (d < 32'd10 || r !== OKAY) begin
      n_fails++; $display("FAIL run_cycles: got %0d/%b required >=10/00", d, r);
    end
    axi_write(9'h008, $urandom, 4'hF, r);
    n_checks++;
    if (r !== SLVERR || idata_flat[95:64] !== model_mem[2]) begin
      n_fails++;
      $display("FAIL run_protect: bresp %b word2 %h required 10 %h", r, idata_flat[95:64], model_mem[2]);
    end
    axi_write(9'h100, 32'h3, 4'b0001, r);
    n_checks++;
    if (r !== SLVERR || cpu_running !== 1'b1 || idata_flat !== model_flat()) begin
      n_fails++;
      $display("FAIL run_clear_refused: bresp %b running %b required 10 1 with store intact", r, cpu_running);
    end
  endtask

  task automatic test_clear();
    logic [31:0] d, c1; logic [1:0] r; int unsigned span;
    axi_write(9'h100, 32'h0, 4'b0001, r);
    span = cyc - run_t0;
    n_checks++;
    if (r !== OKAY || cpu_reset !== 1'b1 || cpu_running !== 1'b0) begin
      n_fails++;
      $display("FAIL stop: bresp %b cpu_reset %b running %b required 00 1 0", r, cpu_reset, cpu_running);
    end
    axi_read(9'h104, c1, r);
    n_checks++;
    if (c1 < 32'd10 || c1 > span || r !== OKAY) begin
      n_fails++; $display("FAIL stop_cycles: got %0d required between 10 and %0d", c1, span);
    end
    wait_cycles(5);
    axi_write(9'h100, 32'h2, 4'b0001, r);
    clear_model();
    n_checks++;
    if (r !== OKAY || idata_flat !== '0 || cpu_reset !== 1'b1) begin
      n_fails++;
      $display("FAIL clear: bresp %b word %0d got %h cpu_reset %b required 00 0 1", r,
               first_diff(idata_flat, '0), idata_flat[32*first_diff(idata_flat, '0) +: 32], cpu_reset);
    end
    axi_read(9'h104, d, r);
    n_checks++;
    if (d !== c1) begin n_fails++; $display("FAIL clear_frozen: got %0d required %0d", d, c1); end
    axi_read(9'h100, d, r);
    n_checks++;
    if (d !== 32'h0 || r !== OKAY) begin
      n_fails++; $display("FAIL ctrl_readback: got %h/%b required 00000000/00", d, r);
    end
    axi_write(9'h100, 32'h1, 4'b1110, r);
    n_checks++;
    if (r !== OKAY || cpu_running !== 1'b0) begin
      n_fails++; $display("FAIL ctrl_nostrb0: bresp %b running %b required 00 0", r, cpu_running);
    end
    axi_write(9'h020, $urandom, 4'hF, r);
    axi_write(9'h040, $urandom, 4'hF, r);
    axi_write(9'h100, 32'h3, 4'b0001, r);
    n_checks++;
    if (r !== OKAY || idata_flat !== '0 || cpu_running !== 1'b1) begin
      n_fails++;
      $display("FAIL clear_and_run: bresp %b running %b word %0d got %h required 00 1 0", r, cpu_running,
               first_diff(idata_flat, '0), idata_flat[32*first_diff(idata_flat, '0) +: 32]);
    end
    axi_read(9'h100, d, r);
    n_checks++;
    if (d !== 32'h1) begin n_fails++; $display("FAIL ctrl_run_read: got %h required 00000001", d); end
    axi_write(9'h100, 32'h0, 4'b0001, r);
    wait_cycles(2);
    n_checks++;
    if (cpu_reset !== 1'b1 || cpu_running !== 1'b0) begin
      n_fails++; $display("FAIL final_stop: cpu_reset %b running %b required 1 0", cpu_reset, cpu_running);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_r, wv, d; logic [1:0] r;
    wv = $urandom;
    model_mem[1] = $urandom;
    axi_write(9'h004, model_mem[1], 4'hF, r);
    exp_r = model_mem[1];
    s_bready = 1'b0; s_rready = 1'b0;
    s_awaddr = 9'h024; s_awvalid = 1'b1; s_wdata = wv; s_wstrb = 4'hF; s_wvalid = 1'b1;
    s_araddr = 9'h004; s_arvalid = 1'b1;
    @(posedge clk); #1;
    s_awvalid = 1'b0; s_wvalid = 1'b0; s_arvalid = 1'b0;
    @(posedge clk); #1;
    model_mem[9] = wv;
    s_awaddr = 9'h030; s_awvalid = 1'b1; s_wdata = 32'hDEADBEEF; s_wvalid = 1'b1;
    s_araddr = 9'h000; s_arvalid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if ({s_bvalid, s_rvalid, s_awready, s_wready, s_arready} !== 5'b11000) begin
        n_fails++;
        $display("FAIL hold_handshake: cycle %0d got %b required 11000", i,
                 {s_bvalid, s_rvalid, s_awready, s_wready, s_arready});
      end
      n_checks++;
      if (s_bresp !== OKAY || s_rresp !== OKAY || s_rdata !== exp_r) begin
        n_fails++;
        $display("FAIL hold_data: cycle %0d bresp %b rresp %b rdata %h required 00 00 %h",
                 i, s_bresp, s_rresp, s_rdata, exp_r);
      end
      @(posedge clk); #1;
    end
    n_checks++;
    if (idata_flat !== model_flat()) begin
      n_fails++;
      $display("FAIL hold_store: word %0d got %h required %h", first_diff(idata_flat, model_flat()),
               idata_flat[32*first_diff(idata_flat, model_flat()) +: 32],
               model_mem[first_diff(idata_flat, model_flat())]);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    clear_model();
    n_checks++;
    if ({s_bvalid, s_rvalid, s_awready, s_wready, s_arready} !== 5'b0) begin
      n_fails++;
      $display("FAIL midreset_valids: got %b required 00000", {s_bvalid, s_rvalid, s_awready, s_wready, s_arready});
    end
    n_checks++;
    if (idata_flat !== '0 || cpu_reset !== 1'b1) begin
      n_fails++; $display("FAIL midreset_state: cpu_reset %b store nonzero=%b required 1 0",
                          cpu_reset, idata_flat != '0);
    end
    s_awvalid = 1'b0; s_wvalid = 1'b0; s_arvalid = 1'b0;
    reset = 1'b0;
    wait_cycles(1);
    axi_read(9'h030, d, r);
    n_checks++;
    if (d !== 32'h0 || r !== OKAY || idata_flat !== '0) begin
      n_fails++; $display("FAIL midreset_dropped: word12 got %h/%b required 00000000/00", d, r);
    end
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    s_awaddr = '0; s_awvalid = 1'b0; s_wdata = '0; s_wstrb = '0; s_wvalid = 1'b0; s_bready = 1'b0;
    s_araddr = '0; s_arvalid = 1'b0; s_rready = 1'b0;
    b_creset_seen = 1'b0; run_t0 = 0;
    clear_model();
    for (int k = 0; k < NWORDS; k++) model_regs[k] = '0;
    test_reset();
    test_basic_write();
    test_w_before_aw();
    test_random_inst();
    test_same_cycle_rw();
    test_snapshot();
    test_run();
    test_clear();
    test_backpressure();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/axil_imem_loader.md
Name: axil_imem_loader

Overview:
AXI4-Lite slave that sits directly upstream of the CPU test harness. It holds the 32-word instruction store that drives the harness instruction inputs and lets the processing system read the CPU register snapshot. A control register gates the CPU's reset, and a run-cycle counter tracks execution. Software loads the program, then runs and inspects the CPU without reconfiguring the fabric.

Parameters:
ADDR_W, 9, AXI address width; bits [8:2] select the word, bits [1:0] are ignored.
NWORDS, 32, number of instruction words and of register snapshot words (fixed at 32).

Ports:
clk  in  1  system clock; all logic is on the rising edge.
reset  in  1  synchronous, active-high reset.
s_awaddr  in  ADDR_W  write address.
s_awvalid  in  1  write address valid.
s_awready  out  1  write address ready.
s_wdata  in  32  write data.
s_wstrb  in  4  byte enables.
s_wvalid  in  1  write data valid.
s_wready  out  1  write data ready.
s_bresp  out  2  write response: 00 = OKAY, 10 = SLVERR.
s_bvalid  out  1  write response valid.
s_bready  in  1  write response ready.
s_araddr  in  ADDR_W  read address.
s_arvalid  in  1  read address valid.
s_arready  out  1  read address ready.
s_rdata  out  32  read data.
s_rresp  out  2  read response.
s_rvalid  out  1  read data valid.
s_rready  in  1  read data ready.
idata_flat  out  1024  instruction words; word k is at bits [32k+31:32k].
regs_flat  in  1024  CPU register file; word k is register k.
cpu_reset  out  1  reset to the CPU and harness, active-high.
cpu_running  out  1  mirror of the run bit.

Behaviour:
- Address map (byte addresses):
  - 0x000–0x07C: instruction words 0–31, read/write.
  - 0x080–0x0FC: register snapshot 0–31, read-only.
  - 0x100: CTRL. bit0 = run (read/write). bit1 = clear (write-only, self-clearing, reads 0).
  - 0x104: CYCLES, read-only 32-bit run counter.
  - 0x108–0x1FC: unmapped. Reads return 0 with SLVERR; writes are ignored with SLVERR.
- Reset state:
  - All ready and valid outputs 0; bresp, rresp and rdata are 0.
  - All instruction words 0; run=0; CYCLES=0.
  - cpu_reset=1; cpu_running=0.
- Write channel:
  - AW and W are accepted independently. s_awready=1 while no address is latched and bvalid=0; s_wready follows the same rule for data.
  - Once both are held, the write commits in the next cycle and bvalid rises in that same cycle. Only one write is outstanding at a time.
  - bvalid holds until bready is high. AW and W readiness returns the cycle after the B handshake.
  - Byte lanes are written only where wstrb is set. wstrb=0000 gives OKAY and changes nothing.
- Write protection:
  - A write to an instruction word while run=1 is ignored and returns SLVERR.
  - A write to the snapshot area or CYCLES returns SLVERR.
- CTRL writes:
  - CTRL honours only wstrb[0].
  - Writing bit1=1 while run=0 zeroes all 32 instruction words in the commit cycle. Writing bit1=1 while run=1 returns SLVERR and changes nothing, including the run bit.
  - If bit0 and bit1 are both 1 with run=0, the clear happens and run becomes 1.
- Read channel:
  - s_arready=1 when rvalid=0.
  - Data is sampled at the AR handshake; rvalid rises on the next cycle, and rdata/rresp hold stable until rready.
  - Snapshot words are the live regs_flat value at the AR handshake.
- Read and write in the same cycle, same address:
  - The read captures the pre-write value.
  - The write commits in that same cycle, so the next read returns the new value.
- Run and reset timing:
  - cpu_reset is registered: cpu_reset = reset OR NOT run, one cycle after the run bit changes.
  - Example: a CTRL commit at cycle N sets run at N+1, and cpu_reset falls at N+2. cpu_running equals the run bit.
- CYCLES:
  - Clears on the run 0→1 transition.
  - Increments each cycle that run=1 and cpu_reset=0.
  - Saturates at 0xFFFFFFFF and holds its value when run returns to 0.
- Reset asserted mid-transaction:
  - The pending transaction is dropped with no response issued.
  - Every register returns to its reset state on the next edge.
- Response ordering: no interleaving issue arises because there is at most one write and one read outstanding.

Test Plan:
- Write 0x00500093 to 0x000 and 0x00100113 to 0x004 with wstrb=1111. Required: idata_flat[31:0]=0x00500093, [63:32]=0x00100113, both bresp=00, and reading back gives the same values.
- W sent 3 cycles before AW, with wdata=0xAABBCCDD and wstrb=0101 to word 5 (previously 0). Required: word 5 = 0x00BB00DD, and bvalid rises only after AW is accepted.
- Write CTRL=1. Required: cpu_reset falls 2 cycles after the commit. After 10 cycles of run, CYCLES reads ≥10. A write to 0x008 then gives SLVERR with word 2 unchanged.
- Write CTRL=0, then CTRL=0b10. Required: all idata_flat is 0, CYCLES keeps its frozen value, and cpu_reset=1.
- Drive regs_flat word 3 = 0x12345678, then read 0x08C. Required: 0x12345678 with OKAY. Reading 0x150 gives 0 with SLVERR; writing 0x084 gives SLVERR.
- Hold bready=0 and rready=0 for 5 cycles. Required: bvalid/bresp and rvalid/rdata stay stable and no new AW/AR is accepted. Asserting reset mid-hold clears all valids the next cycle.
